// File: rtl/uart_tx_arbiter_pkg.sv
// uart_arb_pkg: shared types and constants for the UART transmit arbiter.
//   arb_state_e  - arbiter FSM states (IDLE, LOCKED)
//   DEF_NUM_REQ  - default number of requesters
//   DEF_DATA_W   - default byte width (matches uart w_data)
//   idx_width()  - width of an index into NUM_REQ requesters (minimum 1)
package uart_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_DATA_W  = 8;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_IDX_W = idx_width(DEF_NUM_REQ);

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side handshake plus uart transmit FIFO
// write port, bundled for the arbiter.
//   req/req_data/req_last - per-requester byte offer (driven by clients)
//   req_ack               - one-hot byte-accepted strobe
//   grant/busy            - registered owner and lock indication
//   tx_full               - uart transmit FIFO full (driven by uart)
//   wr_uart/w_data        - uart transmit FIFO write strobe and byte
// Modports: slave = arbiter side, master = clients/uart side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
) ();

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ack;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;
  logic                      tx_full;
  logic                      wr_uart;
  logic [DATA_W-1:0]         w_data;

  modport slave (
    input  req, req_data, req_last, tx_full,
    output req_ack, grant, busy, wr_uart, w_data
  );

  modport master (
    output req, req_data, req_last, tx_full,
    input  req_ack, grant, busy, wr_uart, w_data
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational rotating priority encoder.
//   req         - request vector
//   last_winner - index of the previous winner; search starts one above it
//   pick        - one-hot winner (all-zero when req == 0)
//   pick_idx    - binary index of the winner (0 when req == 0)
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_winner,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    logic             found;
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    idx      = '0;
    // Walk last_winner+1 .. last_winner+NUM_REQ (mod NUM_REQ); the winner
    // itself is visited last so it has lowest priority.
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'((32'(last_winner) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin arbiter sharing the single
// uart transmit FIFO write port between NUM_REQ byte-stream requesters.
// Once granted, a requester keeps the transmitter until it sends a byte
// flagged last.
//   clk   - system clock
//   reset - asynchronous, active-high reset
//   bus   - uart_tx_arbiter_if.slave (requests, acks, grant, uart write port)
// Optional feature: define UART_ARB_TIMEOUT_EN to release a grant after
// TIMEOUT_CYCLES consecutive cycles without a transfer.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_winner_q, last_winner_d;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;

  logic               owner_req;
  logic               owner_last;
  logic [DATA_W-1:0]  owner_data;
  logic               transfer;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req         (bus.req),
    .last_winner (last_winner_q),
    .pick        (pick),
    .pick_idx    (pick_idx)
  );

  // Owner's request/last/data muxed by the one-hot registered grant.
  always_comb begin
    owner_req  = 1'b0;
    owner_last = 1'b0;
    owner_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        owner_req  = bus.req[i];
        owner_last = bus.req_last[i];
        owner_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign transfer = (state_q == LOCKED) && owner_req && !bus.tx_full;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      last_winner_q <= IDX_W'(NUM_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      last_winner_q <= last_winner_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    last_winner_d = last_winner_q;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = LOCKED;
          grant_d = pick;
          owner_d = pick_idx;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      LOCKED: begin
        if (transfer && owner_last) begin
          state_d       = IDLE;
          grant_d       = '0;
          last_winner_d = owner_q;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_d         = '0;
        end else if (transfer) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Stalled owner: release without writing, rotate past it.
          state_d       = IDLE;
          grant_d       = '0;
          last_winner_d = owner_q;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Outputs: all write-side signals are zero unless a transfer happens.
  always_comb begin
    bus.grant   = grant_q;
    bus.busy    = (state_q == LOCKED);
    bus.wr_uart = transfer;
    bus.w_data  = transfer ? owner_data : '0;
    bus.req_ack = transfer ? grant_q : '0;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmit FIFO write port (wr_uart / w_data / tx_full) between NUM_REQ byte-stream requesters. Arbitration is packet-locked: once granted, a requester keeps the transmitter until it sends a byte flagged last, so multi-byte messages are never interleaved. It sits between client logic (loopback, status reporters, command responders) and the uart block's transmit side.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, byte width; matches uart w_data
- TIMEOUT_CYCLES, 1024, stall limit before forced release (used only with UART_ARB_TIMEOUT_EN)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  requester i has a valid byte on its data slice
- req_data  in  NUM_REQ*DATA_W  byte from requester i in bits [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  byte offered by requester i ends its packet
- req_ack  out  NUM_REQ  one-hot; byte of requester i accepted this cycle
- grant  out  NUM_REQ  one-hot registered owner; all-zero when idle
- busy  out  1  a requester holds the transmitter
- tx_full  in  1  uart transmit FIFO full
- wr_uart  out  1  write strobe to uart transmit FIFO
- w_data  out  DATA_W  byte to uart transmit FIFO

## Operation
- States: IDLE, LOCKED. Registers: state, grant, last_winner pointer, timeout counter (if enabled).
- IDLE: if req != 0, the round-robin picker selects the first set req starting at last_winner+1 (modulo NUM_REQ); grant is loaded and state goes to LOCKED. If req == 0, stay.
- LOCKED with owner g: transfer = req[g] & ~tx_full. When transfer: wr_uart = 1, w_data = req_data slice g, req_ack[g] = 1 (all combinational from registered grant).
- Transfer with req_last[g] = 1: next state IDLE, grant cleared, last_winner <= g.
- Owner deasserting req without last: grant held (packet lock); no write issued.
- Non-owner requests are ignored while LOCKED; they are not acked and must hold req/data stable until acked.
- tx_full = 1: no write or ack; owner holds its byte. wr_uart is never asserted while tx_full = 1.
- req_ack, wr_uart, w_data are zero in IDLE. w_data is zero whenever wr_uart = 0.

## Timing
- Reset: state IDLE, grant 0, busy 0, last_winner NUM_REQ-1 (requester 0 wins first), counter 0; req_ack 0, wr_uart 0, w_data 0.
- Request seen in IDLE at cycle n -> grant/busy high at n+1; first byte may transfer at n+1.
- Steady state: one byte per cycle while req[g] & ~tx_full.
- Last byte at cycle m -> IDLE at m+1 (grant 0), next grant at m+2 at earliest; exactly one idle bubble between packets.
- Single-byte packet: req with req_last both high; granted n+1, acked n+1, idle n+2.
- Reset asserted mid-packet: immediately IDLE, grant cleared, partial packet abandoned; no recovery of bytes already written.

## Configuration
- UART_ARB_TIMEOUT_EN defined: in LOCKED, counter increments each cycle with no transfer and clears on any transfer; on reaching TIMEOUT_CYCLES-1 the grant is released (IDLE next cycle, last_winner <= g) without writing anything. Counter width clog2(TIMEOUT_CYCLES).
- Not defined: no counter; a stalled owner holds the transmitter indefinitely (tx_full stalls also never release).

## Structure
- Package uart_arb_pkg: state enum (IDLE, LOCKED), default NUM_REQ/DATA_W constants, index-width helper constant.
- Sub-module rr_picker: combinational rotating priority encoder (inputs req, last_winner; output one-hot pick and index). Everything else in uart_tx_arbiter.

## Test plan
- After reset, req = 4'b0101 both single-byte (0x41, 0x42) -> grant 0001 first, wr_uart with 0x41; then grant 0100, 0x42; one bubble between.
- Requester 1 sends 3-byte packet 0x10,0x11,0x12 (last on 0x12) while requester 2 requests throughout -> three consecutive writes from 1, no 2 bytes interleaved, then 2 granted.
- tx_full held high 5 cycles mid-packet -> no wr_uart/req_ack during those cycles, byte written on first cycle tx_full = 0, data unchanged.
- All four request continuously with single-byte packets -> grant order 0,1,2,3,0 (fair rotation).
- Reset pulsed during LOCKED -> grant 0, busy 0, wr_uart 0 same cycle; next request from 0 granted first.
- With UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: owner drops req mid-packet -> grant released after 16 stalled cycles, other requester then granted; without macro, grant held for 100+ cycles.
